// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : VLIW front end. Owns the PC, issues fetch requests to the
//             instruction memory, buffers returned {pc, word} pairs in a
//             small FIFO and hands them to decode over valid/ready.
//             Absorbs memory misses, decode back-pressure and redirects.
//  Ports    : clk, reset (sync, active-high)
//             imem_pc/imem_req -> memory; imem_word/imem_hit <- memory
//             redirect_valid/redirect_pc <- execute
//             dec_valid/dec_instr/dec_pc -> decode; dec_ready <- decode
//             miss_count : saturating count of missed request cycles
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   output logic        imem_req,
   input  logic [31:0] imem_word,
   input  logic        imem_hit,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   input  logic        dec_ready,
   output logic [15:0] miss_count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_MISS = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [15:0]   miss_q, miss_d;

   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   word_mem_q [DEPTH];

   logic full_w, empty_w, req_w, push_w, pop_w;

   always_comb begin
      full_w  = (cnt_q == FULL_CNT);
      empty_w = (cnt_q == '0);
      // While missing no entry can be added, so a request is always safe.
      req_w   = !reset && ((state_q == S_MISS) || !full_w);
      // A redirect drops any word returned in the same cycle.
      push_w  = req_w && imem_hit && !redirect_valid;
      pop_w   = !reset && !empty_w && dec_ready;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      miss_d  = miss_q;

      if (req_w && !imem_hit && (miss_q != 16'hFFFF)) begin
         miss_d = miss_q + 16'd1;
      end

      if (redirect_valid) begin
         // Flush wins over any concurrent push or pop bookkeeping.
         state_d = S_RUN;
         pc_d    = redirect_pc;
         cnt_d   = '0;
         wr_d    = '0;
         rd_d    = '0;
      end else begin
         if (req_w) begin
            state_d = imem_hit ? S_RUN : S_MISS;
         end
         if (push_w) begin
            pc_d = pc_q + PC_STEP;
            wr_d = wr_q + AW'(1);
         end
         if (pop_w) begin
            rd_d = rd_q + AW'(1);
         end
         if (push_w && !pop_w) begin
            cnt_d = cnt_q + (AW+1)'(1);
         end else if (!push_w && pop_w) begin
            cnt_d = cnt_q - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         miss_q  <= miss_d;
      end
   end

   // Storage needs no reset: entries are only visible through cnt_q.
   always_ff @(posedge clk) begin
      if (!reset && push_w) begin
         pc_mem_q[wr_q]   <= pc_q;
         word_mem_q[wr_q] <= imem_word;
      end
   end

   always_comb begin
      imem_pc    = pc_q;
      imem_req   = req_w;
      dec_valid  = !reset && !empty_w;
      dec_instr  = dec_valid ? word_mem_q[rd_q] : 32'd0;
      dec_pc     = dec_valid ? pc_mem_q[rd_q]   : 32'd0;
      miss_count = reset ? 16'd0 : miss_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Directed self-checking bench for instr_fetch_unit: reset,
//             streaming, back-pressure, miss, redirect, PC wrap, miss
//             counter saturation and reset during a miss.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, imem_hit, redirect_valid, dec_ready;
   logic [31:0] redirect_pc, imem_word;
   logic [31:0] imem_pc, dec_instr, dec_pc;
   logic        imem_req, dec_valid;
   logic [15:0] miss_count;

   // Second instance starting near the top of the address space.
   logic        reset_w, dec_ready_w;
   logic [31:0] imem_pc_w, dec_instr_w, dec_pc_w;
   logic        imem_req_w, dec_valid_w;
   logic [15:0] miss_count_w;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Memory model: the word at address a is a*3.
   always_comb imem_word = imem_pc * 32'd3;

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd1)) dut (
      .clk(clk), .reset(reset),
      .imem_pc(imem_pc), .imem_req(imem_req),
      .imem_word(imem_word), .imem_hit(imem_hit),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
      .dec_ready(dec_ready), .miss_count(miss_count)
   );

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE), .PC_STEP(32'd1)) dut_wrap (
      .clk(clk), .reset(reset_w),
      .imem_pc(imem_pc_w), .imem_req(imem_req_w),
      .imem_word(imem_pc_w), .imem_hit(1'b1),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .dec_valid(dec_valid_w), .dec_instr(dec_instr_w), .dec_pc(dec_pc_w),
      .dec_ready(dec_ready_w), .miss_count(miss_count_w)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] wrap_exp [4];
      wrap_exp[0] = 32'hFFFF_FFFE;
      wrap_exp[1] = 32'hFFFF_FFFF;
      wrap_exp[2] = 32'h0000_0000;
      wrap_exp[3] = 32'h0000_0001;

      reset = 1'b1; imem_hit = 1'b1; dec_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      reset_w = 1'b1; dec_ready_w = 1'b0;

      // ---- reset cycle outputs of the main instance ----
      tick();
      check_eq("rst_req",   {31'd0, imem_req},  32'd0);
      check_eq("rst_valid", {31'd0, dec_valid}, 32'd0);
      check_eq("rst_miss",  {16'd0, miss_count}, 32'd0);
      check_eq("rst_decpc", dec_pc, 32'd0);
      check_eq("rst_instr", dec_instr, 32'd0);

      // ---- PC wrap on the second instance (main held in reset) ----
      reset_w = 1'b0; #1;
      repeat (4) tick();
      check_eq("wrap_full_req", {31'd0, imem_req_w}, 32'd0);
      dec_ready_w = 1'b1; #1;
      for (int i = 0; i < 4; i++) begin
         check_eq("wrap_pc",    dec_pc_w,    wrap_exp[i]);
         check_eq("wrap_instr", dec_instr_w, wrap_exp[i]);
         tick();
      end

      // ---- reset then stream ----
      reset = 1'b0; #1;
      check_eq("s_req0",   {31'd0, imem_req},  32'd1);
      check_eq("s_pc0",    imem_pc,            32'd0);
      check_eq("s_valid0", {31'd0, dec_valid}, 32'd0);
      tick();
      for (int k = 0; k < 6; k++) begin
         check_eq("s_valid", {31'd0, dec_valid}, 32'd1);
         check_eq("s_pc",    dec_pc,    32'(k));
         check_eq("s_instr", dec_instr, 32'(3 * k));
         tick();
      end
      check_eq("s_miss", {16'd0, miss_count}, 32'd0);

      // ---- back-pressure ----
      reset = 1'b1; tick();
      reset = 1'b0; dec_ready = 1'b0; #1;
      repeat (4) tick();
      check_eq("bp_req_full", {31'd0, imem_req}, 32'd0);
      check_eq("bp_pc_hold",  imem_pc, 32'd4);
      check_eq("bp_head",     dec_pc,  32'd0);
      repeat (6) tick();
      check_eq("bp_req_still", {31'd0, imem_req}, 32'd0);
      check_eq("bp_pc_still",  imem_pc, 32'd4);
      check_eq("bp_head_stbl", dec_pc,  32'd0);
      check_eq("bp_instr_stbl", dec_instr, 32'd0);
      dec_ready = 1'b1; #1;
      for (int j = 0; j < 8; j++) begin
         check_eq("bp_valid", {31'd0, dec_valid}, 32'd1);
         check_eq("bp_pc",    dec_pc,    32'(j));
         check_eq("bp_instr", dec_instr, 32'(3 * j));
         tick();
      end

      // ---- miss at pc 7 ----
      reset = 1'b1; tick();
      reset = 1'b0; #1;
      repeat (7) tick();
      check_eq("m_pc_start", imem_pc, 32'd7);
      imem_hit = 1'b0; #1;
      repeat (5) tick();
      check_eq("m_pc_hold", imem_pc, 32'd7);
      check_eq("m_count",   {16'd0, miss_count}, 32'd5);
      check_eq("m_nopush",  {31'd0, dec_valid}, 32'd0);
      check_eq("m_req",     {31'd0, imem_req},  32'd1);
      imem_hit = 1'b1; #1;
      tick();
      check_eq("m_push_v",  {31'd0, dec_valid}, 32'd1);
      check_eq("m_push_pc", dec_pc,    32'd7);
      check_eq("m_push_in", dec_instr, 32'd21);
      check_eq("m_pc_adv",  imem_pc,   32'd8);

      // ---- redirect with 3 entries buffered and a hit in flight ----
      dec_ready = 1'b0; #1;
      tick(); tick();
      check_eq("r_head_stbl", dec_pc, 32'd7);
      check_eq("r_pc_pre",    imem_pc, 32'd10);
      redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      tick();
      redirect_valid = 1'b0; #1;
      check_eq("r_valid",  {31'd0, dec_valid}, 32'd0);
      check_eq("r_pc",     imem_pc, 32'h40);
      check_eq("r_req",    {31'd0, imem_req}, 32'd1);
      check_eq("r_empty_pc",    dec_pc,    32'd0);
      check_eq("r_empty_instr", dec_instr, 32'd0);
      check_eq("r_miss_kept", {16'd0, miss_count}, 32'd5);
      dec_ready = 1'b1; #1;
      tick();
      check_eq("r_first_pc",    dec_pc,    32'h40);
      check_eq("r_first_instr", dec_instr, 32'hC0);

      // ---- buffer two entries, then miss long enough to saturate ----
      dec_ready = 1'b0; #1;
      tick();
      imem_hit = 1'b0; #1;
      repeat (70000) tick();
      check_eq("sat_count", {16'd0, miss_count}, 32'h0000_FFFF);
      check_eq("sat_pc",    imem_pc, 32'h42);
      check_eq("sat_head",  dec_pc,  32'h40);

      // ---- reset during the miss ----
      reset = 1'b1; #1;
      check_eq("rm_rst_req",   {31'd0, imem_req},  32'd0);
      check_eq("rm_rst_valid", {31'd0, dec_valid}, 32'd0);
      tick();
      reset = 1'b0; #1;
      check_eq("rm_valid", {31'd0, dec_valid}, 32'd0);
      check_eq("rm_pc",    imem_pc, 32'd0);
      check_eq("rm_miss",  {16'd0, miss_count}, 32'd0);
      check_eq("rm_req",   {31'd0, imem_req}, 32'd1);
      imem_hit = 1'b1; #1;
      tick();
      check_eq("rm_push_pc", dec_pc,  32'd0);
      check_eq("rm_pc_adv",  imem_pc, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
